// File: rtl/button_event_gen.sv
// Two-channel push-button front end: synchronise, debounce, classify each press
// as short or long, and stretch the resulting event pulses for slower consumers.
module button_event_gen #(
    parameter int DEB_CYCLES  = 100000,
    parameter int LONG_CYCLES = 100000000,
    parameter int EVT_HOLD    = 1,
    parameter int CNT_W       = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn0_raw,
    input  logic btn1_raw,
    output logic b0short,
    output logic b0long,
    output logic b1short,
    output logic b1long,
    output logic b0held,
    output logic b1held
);

    localparam int HOLD_W = $clog2(EVT_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        LONG
    } state_t;

    logic [1:0] raw;
    logic [1:0] short_evt;
    logic [1:0] long_evt;
    logic [1:0] held;

    assign raw = {btn1_raw, btn0_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic              sync1;
        logic              sync2;
        logic              deb;
        logic [CNT_W-1:0]  deb_cnt;
        logic [CNT_W-1:0]  hold_cnt;
        logic [CNT_W-1:0]  hold_cnt_next;
        state_t            state;
        state_t            state_next;
        logic              emit_short;
        logic              emit_long;
        logic [HOLD_W-1:0] short_cnt;
        logic [HOLD_W-1:0] long_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= raw[ch];
                sync2 <= sync1;
            end
        end

        // Any agreement restarts the window, so only an unbroken run of
        // DEB_CYCLES disagreeing samples moves the debounced level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                deb     <= 1'b0;
                deb_cnt <= '0;
            end else if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= IDLE;
                hold_cnt <= '0;
            end else begin
                state    <= state_next;
                hold_cnt <= hold_cnt_next;
            end
        end

        // Release is checked before the threshold so a fall on the threshold
        // cycle is still a short press.
        always_comb begin
            state_next    = state;
            hold_cnt_next = hold_cnt;
            emit_short    = 1'b0;
            emit_long     = 1'b0;
            case (state)
                IDLE: begin
                    if (deb) begin
                        state_next    = PRESS;
                        hold_cnt_next = '0;
                    end
                end
                PRESS: begin
                    if (!deb) begin
                        state_next = IDLE;
                        emit_short = 1'b1;
                    end else if (hold_cnt == CNT_W'(LONG_CYCLES - 1)) begin
                        state_next = LONG;
                        emit_long  = 1'b1;
                    end else begin
                        hold_cnt_next = hold_cnt + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (!deb) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // A fresh event reloads the stretch counter, restarting the pulse.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                short_cnt <= '0;
                long_cnt  <= '0;
            end else begin
                if (emit_short) begin
                    short_cnt <= HOLD_W'(EVT_HOLD);
                end else if (short_cnt != '0) begin
                    short_cnt <= short_cnt - HOLD_W'(1);
                end
                if (emit_long) begin
                    long_cnt <= HOLD_W'(EVT_HOLD);
                end else if (long_cnt != '0) begin
                    long_cnt <= long_cnt - HOLD_W'(1);
                end
            end
        end

        assign short_evt[ch] = (short_cnt != '0);
        assign long_evt[ch]  = (long_cnt != '0);
        assign held[ch]      = (state == LONG);
    end

    assign b0short = short_evt[0];
    assign b1short = short_evt[1];
    assign b0long  = long_evt[0];
    assign b1long  = long_evt[1];
    assign b0held  = held[0];
    assign b1held  = held[1];

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen: a run-length reference model predicts
// every event edge; a negedge monitor pops and compares as the DUT produces them.
`timescale 1ns/1ps
module tb_button_event_gen;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int HOLD = 3;

    // Event kinds: 0 short rise, 1 long rise, 2 held fall, 3 held rise
    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn0_raw = 1'b0;
    logic btn1_raw = 1'b0;
    logic b0short, b0long, b1short, b1long, b0held, b1held;

    ev_t exq0[$];
    ev_t exq1[$];
    int  runs0[$];
    int  runs1[$];
    bit  rq0[$];
    bit  rq1[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    logic [1:0] sh, lg, hd, psh, plg, phd;
    int wsh[2];
    int wlg[2];

    button_event_gen #(
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG),
        .EVT_HOLD   (HOLD),
        .CNT_W      (27)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn0_raw(btn0_raw),
        .btn1_raw(btn1_raw),
        .b0short (b0short),
        .b0long  (b0long),
        .b1short (b1short),
        .b1long  (b1long),
        .b0held  (b0held),
        .b1held  (b1held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    function automatic void push_exp(input int ch, input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        if (ch == 0) exq0.push_back(e);
        else exq1.push_back(e);
    endfunction

    function automatic void add_run(input int ch, input int v, input int len);
        if (ch == 0) runs0.push_back((v << 16) | len);
        else runs1.push_back((v << 16) | len);
    endfunction

    // Debounced level moves only when a raw run of the opposite value lasts at
    // least DEB samples, 2+DEB edges after that run begins. A debounced press is
    // long if it is still high LONG edges after its rise, otherwise short.
    function automatic void model(input int ch, input int base);
        bit r[$];
        bit deb = 1'b0;
        int tog[$];
        int i = 0;
        int j;
        if (ch == 0) r = rq0;
        else r = rq1;
        while (i < r.size()) begin
            j = i;
            while (j < r.size() && r[j] == r[i]) j++;
            if (r[i] != deb && (j - i) >= DEB) begin
                deb = r[i];
                tog.push_back(base + i + 2 + DEB);
            end
            i = j;
        end
        for (int k = 0; k + 1 < tog.size(); k += 2) begin
            int d = tog[k];
            int f = tog[k + 1];
            if (f > d + LONG) begin
                push_exp(ch, 1, d + LONG + 1);
                push_exp(ch, 3, d + LONG + 1);
                push_exp(ch, 2, f + 1);
            end else begin
                push_exp(ch, 0, f + 1);
            end
        end
    endfunction

    function automatic void expect_event(input int ch, input int kind);
        ev_t e;
        int  sz;
        sz = (ch == 0) ? exq0.size() : exq1.size();
        check(sz > 0, $sformatf("ch%0d_unexpected_event_kind", ch), kind, -1);
        if (sz == 0) return;
        if (ch == 0) e = exq0.pop_front();
        else e = exq1.pop_front();
        check(e.kind == kind, $sformatf("ch%0d_event_kind", ch), kind, e.kind);
        check(e.cyc == cyc, $sformatf("ch%0d_event_cycle_kind%0d", ch, e.kind), cyc, e.cyc);
    endfunction

    always @(negedge clk) begin
        sh = {b1short, b0short};
        lg = {b1long, b0long};
        hd = {b1held, b0held};
        if (!mon_en) begin
            psh = '0;
            plg = '0;
            phd = '0;
            wsh[0] = 0; wsh[1] = 0;
            wlg[0] = 0; wlg[1] = 0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (sh[ch] && !psh[ch]) expect_event(ch, 0);
                if (lg[ch] && !plg[ch]) expect_event(ch, 1);
                if (hd[ch] && !phd[ch]) expect_event(ch, 3);
                if (!hd[ch] && phd[ch]) expect_event(ch, 2);
                if (sh[ch]) wsh[ch]++;
                else if (psh[ch]) begin
                    check(wsh[ch] == HOLD, $sformatf("ch%0d_short_width", ch), wsh[ch], HOLD);
                    wsh[ch] = 0;
                end
                if (lg[ch]) wlg[ch]++;
                else if (plg[ch]) begin
                    check(wlg[ch] == HOLD, $sformatf("ch%0d_long_width", ch), wlg[ch], HOLD);
                    wlg[ch] = 0;
                end
            end
            psh = sh;
            plg = lg;
            phd = hd;
        end
    end

    task automatic run_block(input bit release_rst);
        int n;
        rq0.delete();
        rq1.delete();
        foreach (runs0[k]) for (int m = 0; m < (runs0[k] & 16'hFFFF); m++) rq0.push_back(bit'(runs0[k] >> 16));
        foreach (runs1[k]) for (int m = 0; m < (runs1[k] & 16'hFFFF); m++) rq1.push_back(bit'(runs1[k] >> 16));
        n = ((rq0.size() > rq1.size()) ? rq0.size() : rq1.size()) + 30;
        while (rq0.size() < n) rq0.push_back(1'b0);
        while (rq1.size() < n) rq1.push_back(1'b0);
        @(posedge clk);
        #1;
        if (release_rst) begin
            rst    = 1'b0;
            mon_en = 1'b1;
        end
        model(0, cyc);
        model(1, cyc);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            btn0_raw = rq0[i];
            btn1_raw = rq1[i];
        end
        runs0.delete();
        runs1.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check(b0short == 1'b0, {tag, "_b0short"}, int'(b0short), 0);
        check(b0long  == 1'b0, {tag, "_b0long"},  int'(b0long),  0);
        check(b1short == 1'b0, {tag, "_b1short"}, int'(b1short), 0);
        check(b1long  == 1'b0, {tag, "_b1long"},  int'(b1long),  0);
        check(b0held  == 1'b0, {tag, "_b0held"},  int'(b0held),  0);
        check(b1held  == 1'b0, {tag, "_b1held"},  int'(b1held),  0);
    endtask

    // Press button 0, assert reset after `pre` edges with the button held,
    // then release reset and let the still-held button count as a new press.
    task automatic reset_mid_press(input int pre, input bit in_long);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        btn0_raw = 1'b1;
        repeat (pre) @(posedge clk);
        #1;
        check(b0held == in_long, "pre_rst_b0held", int'(b0held), int'(in_long));
        check(b0long == in_long, "pre_rst_b0long", int'(b0long), int'(in_long));
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        add_run(0, 1, 30);
        run_block(1'b1);
    endtask

    function automatic int pick_len();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(1, 3));
            1:       return int'($urandom_range(4, 8));
            2:       return int'($urandom_range(17, 24));
            default: return int'($urandom_range(25, 45));
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Bounce: toggling every 2 cycles never debounces
        for (int k = 0; k < 3; k++) begin
            add_run(0, 1, 2);
            add_run(0, 0, 2);
        end
        run_block(1'b1);

        add_run(0, 1, 10);
        run_block(1'b0);

        add_run(0, 1, 40);
        run_block(1'b0);

        // Threshold: 20 debounced-high cycles is released on the threshold cycle
        add_run(0, 1, 20);
        run_block(1'b0);
        add_run(0, 1, 21);
        run_block(1'b0);

        add_run(0, 1, 45);
        add_run(1, 0, 30);
        add_run(1, 1, 8);
        run_block(1'b0);

        reset_mid_press(16, 1'b0);
        reset_mid_press(28, 1'b1);

        for (int b = 0; b < 25; b++) begin
            for (int ch = 0; ch < 2; ch++) begin
                int nr = int'($urandom_range(4, 10));
                for (int r = 0; r < nr; r++) add_run(ch, int'($urandom_range(0, 1)), pick_len());
            end
            run_block(1'b0);
        end

        repeat (10) @(posedge clk);
        #1;
        check(exq0.size() == 0, "ch0_pending_events", exq0.size(), 0);
        check(exq1.size() == 0, "ch1_pending_events", exq1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
